// File: rtl/ascon_pkg.sv
// Shared definitions for the Ascon serial-output collector: FSM encoding,
// tag width and a constant max helper used for sizing the capture window.
package ascon_pkg;

   localparam int TAG_W = 128;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_HOLD  = 2'd3
   } colState_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/ascon_sipo.sv
// LSB-first serial-to-parallel capture: bit_in lands in q[index] when enabled.
// Indices at or beyond W match no bit position and are dropped.
module ascon_sipo #(
   parameter int W  = 40,
   parameter int IW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          enable,
   input  logic [IW-1:0] index,
   input  logic          bit_in,
   output logic [W-1:0]  q
);

   // Clear on a new run, otherwise write the addressed bit only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (clear) begin
         q <= '0;
      end else if (enable) begin
         for (int j = 0; j < W; j++) begin
            if (index == IW'(j)) q[j] <= bit_in;
         end
      end
   end

endmodule

// File: rtl/ascon_so_collector.sv
// Collects the Ascon core's serial ciphertext and tag after encryption_ready
// rises, presents them with a valid/ready handshake and flags overlapping runs.
// Optional feature macro: ASCON_TAG_CHECK_EN adds tag_expected / tag_match.
module ascon_so_collector
   import ascon_pkg::*;
#(
   parameter int Y    = 40,
   parameter int K    = 128,
   parameter int L    = 40,
   parameter int SKIP = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             encryption_readyxSI,
   input  logic             cipher_textxSI,
   input  logic             tagxSI,
   output logic [Y-1:0]     cipher_text,
   output logic [TAG_W-1:0] tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
`ifdef ASCON_TAG_CHECK_EN
   output logic             overrun,
   input  logic [TAG_W-1:0] tag_expected,
   output logic             tag_match
`else
   output logic             overrun
`endif
);

   // Capture window covers the longest field; MAX >= 128 so IW >= 7.
   localparam int MAX = max3(max3(K, Y, L), TAG_W, 0);
   localparam int IW  = $clog2(MAX);
   localparam int CW  = (SKIP > 1) ? $clog2(SKIP + 1) : 1;

   colState_t     state, stateNext;
   logic [CW-1:0] waitCnt, waitCntNext;
   logic [IW-1:0] idx, idxNext;
   logic          readyPrev;
   logic          readyEdge;
   logic          clearCap;
   logic          shiftEn;
   logic          setOverrun;

   // History starts at 0, so a level already high after reset is an edge.
   assign readyEdge = encryption_readyxSI & ~readyPrev;
   assign out_valid = (state == ST_HOLD);
   assign busy      = (state != ST_IDLE);

   // State, counters, ready history and sticky overrun.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         waitCnt   <= '0;
         idx       <= '0;
         readyPrev <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state     <= stateNext;
         waitCnt   <= waitCntNext;
         idx       <= idxNext;
         readyPrev <= encryption_readyxSI;
         if (setOverrun) overrun <= 1'b1;
      end
   end

   // Next state and capture controls; edges outside IDLE only raise overrun.
   always_comb begin
      stateNext   = state;
      waitCntNext = waitCnt;
      idxNext     = idx;
      clearCap    = 1'b0;
      shiftEn     = 1'b0;
      setOverrun  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (readyEdge) begin
               clearCap    = 1'b1;
               idxNext     = '0;
               waitCntNext = CW'(SKIP);
               // With no idle gap the first bit is taken the very next cycle.
               stateNext   = (SKIP == 0) ? ST_SHIFT : ST_WAIT;
            end
         end
         ST_WAIT: begin
            setOverrun  = readyEdge;
            waitCntNext = waitCnt - CW'(1);
            if (waitCnt <= CW'(1)) stateNext = ST_SHIFT;
         end
         ST_SHIFT: begin
            setOverrun = readyEdge;
            shiftEn    = 1'b1;
            idxNext    = idx + IW'(1);
            if (idx == IW'(MAX - 1)) begin
               idxNext   = '0;
               stateNext = ST_HOLD;
            end
         end
         ST_HOLD: begin
            // A simultaneous edge is still ignored; the transfer completes.
            setOverrun = readyEdge;
            if (out_ready) stateNext = ST_IDLE;
         end
         default: stateNext = ST_IDLE;
      endcase
   end

   ascon_sipo #(.W(Y), .IW(IW)) ctCap (
      .clk    (clk),
      .rst    (rst),
      .clear  (clearCap),
      .enable (shiftEn),
      .index  (idx),
      .bit_in (cipher_textxSI),
      .q      (cipher_text)
   );

   ascon_sipo #(.W(TAG_W), .IW(IW)) tagCap (
      .clk    (clk),
      .rst    (rst),
      .clear  (clearCap),
      .enable (shiftEn),
      .index  (idx),
      .bit_in (tagxSI),
      .q      (tag)
   );

`ifdef ASCON_TAG_CHECK_EN
   logic [TAG_W-1:0] tagNext;

   // Tag value as it will be after this edge, so the registered match lines
   // up with out_valid including the cycle where the last bit lands.
   always_comb begin
      tagNext = tag;
      if (shiftEn) begin
         for (int j = 0; j < TAG_W; j++) begin
            if (idx == IW'(j)) tagNext[j] = tagxSI;
         end
      end
   end

   // Registered compare, forced low whenever out_valid will be low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) tag_match <= 1'b0;
      else     tag_match <= (stateNext == ST_HOLD) && (tagNext == tag_expected);
   end
`endif

endmodule

// File: tb/tb_ascon_so_collector.sv
// Scoreboard bench for ascon_so_collector: default instance plus a SKIP=0,
// Y=160 instance. Optional macro ASCON_TAG_CHECK_EN enables tag_match checks.
module tb_ascon_so_collector;

   localparam int SKIP0 = 2;
   localparam int MAX0  = 128;
   localparam int SKIP1 = 0;
   localparam int MAX1  = 160;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic rdy0 = 1'b0, ctb0 = 1'b0, tgb0 = 1'b0, ordy0 = 1'b0;
   logic [39:0]  ct0;
   logic [127:0] tg0;
   logic ov0, busy0, ovr0;

   logic rdy1 = 1'b0, ctb1 = 1'b0, tgb1 = 1'b0, ordy1 = 1'b0;
   logic [159:0] ct1;
   logic [127:0] tg1;
   logic ov1, busy1, ovr1;

`ifdef ASCON_TAG_CHECK_EN
   logic [127:0] texp0 = '0, texp1 = '0;
   logic tm0, tm1;
`endif

   always #5 clk = ~clk;

   ascon_so_collector dut0 (
      .clk(clk), .rst(rst), .encryption_readyxSI(rdy0), .cipher_textxSI(ctb0),
      .tagxSI(tgb0), .cipher_text(ct0), .tag(tg0), .out_valid(ov0),
      .out_ready(ordy0), .busy(busy0),
`ifdef ASCON_TAG_CHECK_EN
      .tag_expected(texp0), .tag_match(tm0),
`endif
      .overrun(ovr0)
   );

   ascon_so_collector #(.Y(160), .SKIP(0)) dut1 (
      .clk(clk), .rst(rst), .encryption_readyxSI(rdy1), .cipher_textxSI(ctb1),
      .tagxSI(tgb1), .cipher_text(ct1), .tag(tg1), .out_valid(ov1),
      .out_ready(ordy1), .busy(busy1),
`ifdef ASCON_TAG_CHECK_EN
      .tag_expected(texp1), .tag_match(tm1),
`endif
      .overrun(ovr1)
   );

   typedef struct {
      logic [159:0] ct;
      logic [127:0] tg;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int nTests = 0;
   int nFail  = 0;

   // Stream one run into dut0; ev=1 adds a second ready edge at index 50,
   // ev=2 asserts reset at index 20 and withdraws the expected result.
   task automatic capture0(input logic [39:0] ct, input logic [127:0] tg,
                           input int ev, input bit armed, output bit aborted);
      exp_t e;
      int i;
      e.ct = 160'(ct);
      e.tg = tg;
      q0.push_back(e);
      aborted = 1'b0;
      if (!armed) begin
         @(posedge clk); #1;
         rdy0 = 1'b1;
      end
      for (int k = 0; k < SKIP0 + MAX0; k++) begin
         @(posedge clk); #1;
         rdy0 = 1'b0;
         i = k - SKIP0;
         if (i >= 0) begin
            ctb0 = (i < 40) ? ct[i] : 1'($urandom);
            tgb0 = tg[i];
         end
         if (ev == 1 && i == 50) rdy0 = 1'b1;
         if (ev == 2 && i == 20) begin
            rst = 1'b1;
            #1;
            nTests++;
            if ({ov0, busy0, ovr0} !== 3'b000 || ct0 !== '0 || tg0 !== '0) begin
               nFail++;
               $display("FAIL reset_mid: ov=%b busy=%b ovr=%b ct=%h tag=%h want all 0",
                        ov0, busy0, ovr0, ct0, tg0);
            end
            void'(q0.pop_back());
            aborted = 1'b1;
            return;
         end
         if (k == SKIP0 + MAX0 - 1) begin
            nTests++;
            if (ov0 !== 1'b0 || busy0 !== 1'b1) begin
               nFail++;
               $display("FAIL early_valid0: ov=%b busy=%b want 0/1", ov0, busy0);
            end
         end
      end
      @(posedge clk); #1;
      nTests++;
      if (ov0 !== 1'b1) begin
         nFail++;
         $display("FAIL latency0: out_valid=%b want 1 at cycle %0d", ov0, SKIP0 + MAX0 + 1);
      end
   endtask

   // Wait for dut0 result, compare against scoreboard, stall, then transfer.
   task automatic drain0(input int hold, input logic tmExp);
      exp_t e;
      int w;
      bit bad;
      w = 0;
      while (ov0 !== 1'b1 && w < 300) begin
         @(posedge clk); #1;
         w++;
      end
      nTests++;
      if (ov0 !== 1'b1 || q0.size() == 0) begin
         nFail++;
         $display("FAIL wait0: out_valid=%b queued=%0d want 1 and >0", ov0, q0.size());
         return;
      end
      e = q0.pop_front();
      nTests++;
      if (ct0 !== e.ct[39:0] || tg0 !== e.tg) begin
         nFail++;
         $display("FAIL data0: ct=%h tag=%h want ct=%h tag=%h", ct0, tg0, e.ct[39:0], e.tg);
      end
`ifdef ASCON_TAG_CHECK_EN
      nTests++;
      if (tm0 !== tmExp) begin
         nFail++;
         $display("FAIL tag_match0: got %b want %b", tm0, tmExp);
      end
`endif
      if (hold > 0) begin
         bad = 1'b0;
         for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            if (ov0 !== 1'b1 || ct0 !== e.ct[39:0] || tg0 !== e.tg) bad = 1'b1;
         end
         nTests++;
         if (bad) begin
            nFail++;
            $display("FAIL hold0: ov=%b ct=%h tag=%h want 1 %h %h", ov0, ct0, tg0, e.ct[39:0], e.tg);
         end
      end
      ordy0 = 1'b1;
      @(posedge clk); #1;
      ordy0 = 1'b0;
      nTests++;
      if (ov0 !== 1'b0 || busy0 !== 1'b0) begin
         nFail++;
         $display("FAIL transfer0: ov=%b busy=%b want 0/0", ov0, busy0);
      end
`ifdef ASCON_TAG_CHECK_EN
      nTests++;
      if (tm0 !== 1'b0) begin
         nFail++;
         $display("FAIL tag_match_idle0: got %b want 0", tm0);
      end
`else
      if (tmExp === 1'bx) $display("unused");
`endif
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      nTests++;
      if ({ov0, busy0, ovr0, ov1, busy1, ovr1} !== 6'b0 || ct0 !== '0 || tg0 !== '0 ||
          ct1 !== '0 || tg1 !== '0) begin
         nFail++;
         $display("FAIL reset: ov0=%b busy0=%b ovr0=%b ov1=%b busy1=%b ovr1=%b ct0=%h tg0=%h want 0",
                  ov0, busy0, ovr0, ov1, busy1, ovr1, ct0, tg0);
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_basic();
      bit ab;
`ifdef ASCON_TAG_CHECK_EN
      texp0 = 128'h0123456789abcdeffedcba9876543210;
`endif
      capture0(40'h6173636f6e, 128'h0123456789abcdeffedcba9876543210, 0, 1'b0, ab);
      drain0(0, 1'b1);
      nTests++;
      if (ovr0 !== 1'b0) begin
         nFail++;
         $display("FAIL overrun_clean: got %b want 0", ovr0);
      end
   endtask

   task automatic test_hold();
      bit ab;
`ifdef ASCON_TAG_CHECK_EN
      texp0 = 128'hfeedface_cafebabe_00ff00ff_12345678;
`endif
      capture0(40'h3c3c3c3c3c, 128'hfeedface_cafebabe_00ff00ff_12345678, 0, 1'b0, ab);
      drain0(10, 1'b1);
   endtask

   task automatic test_tag_mismatch();
      bit ab;
`ifdef ASCON_TAG_CHECK_EN
      texp0 = 128'h0123456789abcdeffedcba9876543211;
`endif
      capture0(40'h0102030405, 128'h0123456789abcdeffedcba9876543210, 0, 1'b0, ab);
      drain0(0, 1'b0);
   endtask

   task automatic test_overrun();
      bit ab;
`ifdef ASCON_TAG_CHECK_EN
      texp0 = 128'haaaa5555_aaaa5555_aaaa5555_aaaa5555;
`endif
      capture0(40'hc0ffee1234, 128'haaaa5555_aaaa5555_aaaa5555_aaaa5555, 1, 1'b0, ab);
      nTests++;
      if (ovr0 !== 1'b1) begin
         nFail++;
         $display("FAIL overrun_set: got %b want 1", ovr0);
      end
      drain0(0, 1'b1);
      // A clean run afterwards must not clear the sticky flag.
      capture0(40'h1122334455, 128'haaaa5555_aaaa5555_aaaa5555_aaaa5555, 0, 1'b0, ab);
      drain0(0, 1'b1);
      nTests++;
      if (ovr0 !== 1'b1) begin
         nFail++;
         $display("FAIL overrun_sticky: got %b want 1", ovr0);
      end
   endtask

   task automatic test_reset_mid();
      bit ab;
      capture0(40'hffffffffff, {128{1'b1}}, 2, 1'b0, ab);
      nTests++;
      if (ab !== 1'b1) begin
         nFail++;
         $display("FAIL abort_flag: got %b want 1", ab);
      end
      // Ready held high through reset release must start the next run.
      rdy0 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
`ifdef ASCON_TAG_CHECK_EN
      texp0 = 128'h00000000_00000000_00000000_0000a5a5;
`endif
      capture0(40'h5a5a5a5a5a, 128'h00000000_00000000_00000000_0000a5a5, 0, 1'b1, ab);
      drain0(0, 1'b1);
      nTests++;
      if (ovr0 !== 1'b0) begin
         nFail++;
         $display("FAIL overrun_after_reset: got %b want 0", ovr0);
      end
   endtask

   task automatic test_back_to_back();
      bit ab;
`ifdef ASCON_TAG_CHECK_EN
      texp0 = 128'h13579bdf_2468ace0_13579bdf_2468ace0;
`endif
      capture0(40'h8070605040, 128'h13579bdf_2468ace0_13579bdf_2468ace0, 0, 1'b0, ab);
      drain0(0, 1'b1);
      capture0(40'h0f1e2d3c4b, 128'h13579bdf_2468ace0_13579bdf_2468ace0, 0, 1'b0, ab);
      drain0(0, 1'b1);
   endtask

   task automatic test_skip0();
      exp_t e;
      logic [159:0] cts;
      logic [159:0] tgs;
      int w;
      cts = {32'h9abcdef0, 128'h00112233_44556677_8899aabb_ccddeeff};
      tgs = {32'hdeadbeef, 128'h0123456789abcdeffedcba9876543210};
      e.ct = cts;
      e.tg = tgs[127:0];
      q1.push_back(e);
`ifdef ASCON_TAG_CHECK_EN
      texp1 = tgs[127:0];
`endif
      @(posedge clk); #1;
      rdy1 = 1'b1;
      for (int k = 0; k < SKIP1 + MAX1; k++) begin
         @(posedge clk); #1;
         rdy1 = 1'b0;
         ctb1 = cts[k - SKIP1];
         tgb1 = tgs[k - SKIP1];
         if (k == SKIP1 + MAX1 - 1) begin
            nTests++;
            if (ov1 !== 1'b0) begin
               nFail++;
               $display("FAIL early_valid1: ov=%b want 0", ov1);
            end
         end
      end
      @(posedge clk); #1;
      nTests++;
      if (ov1 !== 1'b1) begin
         nFail++;
         $display("FAIL latency1: out_valid=%b want 1 at cycle %0d", ov1, SKIP1 + MAX1 + 1);
      end
      w = 0;
      while (ov1 !== 1'b1 && w < 300) begin
         @(posedge clk); #1;
         w++;
      end
      e = q1.pop_front();
      nTests++;
      if (ct1 !== e.ct || tg1 !== e.tg) begin
         nFail++;
         $display("FAIL data1: ct=%h tag=%h want ct=%h tag=%h", ct1, tg1, e.ct, e.tg);
      end
`ifdef ASCON_TAG_CHECK_EN
      nTests++;
      if (tm1 !== 1'b1) begin
         nFail++;
         $display("FAIL tag_match1: got %b want 1", tm1);
      end
`endif
      ordy1 = 1'b1;
      @(posedge clk); #1;
      ordy1 = 1'b0;
      nTests++;
      if (ov1 !== 1'b0 || busy1 !== 1'b0) begin
         nFail++;
         $display("FAIL transfer1: ov=%b busy=%b want 0/0", ov1, busy1);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_hold();
      test_tag_mismatch();
      test_overrun();
      test_reset_mid();
      test_back_to_back();
      test_skip0();
      nTests++;
      if (q0.size() != 0 || q1.size() != 0) begin
         nFail++;
         $display("FAIL scoreboard_left: q0=%0d q1=%0d want 0", q0.size(), q1.size());
      end
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ascon_so_collector.md
ASCON_SO_COLLECTOR -- requirements
Module: ascon_so_collector

Interface
REQ-001 SHALL have parameter Y, default 40: ciphertext length in bits.
REQ-002 SHALL have parameter K, default 128: key length in bits.
REQ-003 SHALL have parameter L, default 40: associated-data length in bits.
REQ-004 SHALL have parameter SKIP, default 2: idle cycles between ready detection and the first captured bit.
REQ-005 SHALL use localparam MAX = max(K, Y, L, 128): number of serial bits captured.
REQ-006 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-008 SHALL have port encryption_readyxSI, input, 1: the core's encryption_readyxSO.
REQ-009 SHALL have port cipher_textxSI, input, 1: the core's serial ciphertext bit.
REQ-010 SHALL have port tagxSI, input, 1: the core's serial tag bit.
REQ-011 SHALL have port cipher_text, output, Y: the captured ciphertext.
REQ-012 SHALL have port tag, output, 128: the captured tag.
REQ-013 SHALL have port out_valid, output, 1: cipher_text and tag are valid.
REQ-014 SHALL have port out_ready, input, 1: the consumer accepts the result.
REQ-015 SHALL have port busy, output, 1: the block is in WAIT, SHIFT or HOLD.
REQ-016 SHALL have port overrun, output, 1: sticky flag for a ready edge arriving while busy.

Function
REQ-017 SHALL implement an FSM with states IDLE, WAIT, SHIFT and HOLD.
REQ-018 SHALL register encryption_readyxSI and detect a rising edge as current high AND previous low.
- A level held high SHALL NOT retrigger.
REQ-019 IDLE: on a rising edge, SHALL go to WAIT, load the wait counter with SKIP and clear cipher_text and tag.
REQ-020 WAIT: SHALL decrement the counter each cycle and go to SHIFT when it expires.
- With SKIP=0, SHALL go straight to SHIFT on the next cycle.
REQ-021 SHALL hold a bit index i that starts at 0 and increments on each SHIFT cycle.
REQ-022 In SHIFT cycle i, SHALL capture cipher_textxSI into cipher_text[i] for i<Y and tagxSI into tag[i] for i<128.
- The first bit received is the LSB.
- Bits with index at or above the field width SHALL be discarded.
REQ-023 After MAX SHIFT cycles, SHALL go to HOLD.
- out_valid SHALL assert the cycle after the last capture.
REQ-024 HOLD: cipher_text and tag SHALL remain stable while out_valid is high.
- Transfer happens on a cycle with out_valid and out_ready both high.
- After a transfer, SHALL go to IDLE with out_valid low on the next cycle.
REQ-025 A ready edge detected in WAIT, SHIFT or HOLD SHALL be ignored and SHALL set overrun.
- overrun clears only on reset.
REQ-026 In a HOLD cycle with out_ready high and a simultaneous ready edge, SHALL complete the transfer, go to IDLE and set overrun.
- The new run is not started.
REQ-027 Latency from the edge-detect cycle to out_valid SHALL be SKIP + MAX + 1 cycles.
- For the defaults this is 131.

Reset
REQ-028 While rst is high, SHALL force the following values asynchronously:
- state IDLE;
- counters, cipher_text, tag, overrun, out_valid and busy all 0;
- the ready history register 0.
REQ-029 Reset asserted mid-operation SHALL abort the capture with no partial result presented.
REQ-030 After rst deasserts, an input that is already high SHALL count as a rising edge.

Configuration
REQ-031 SHALL support macro ASCON_TAG_CHECK_EN.
REQ-032 With ASCON_TAG_CHECK_EN defined, SHALL add input tag_expected[127:0] and output tag_match.
- tag_match SHALL be registered and equal (tag == tag_expected) while out_valid is high, else 0.
- Its reset value SHALL be 0.
REQ-033 Without ASCON_TAG_CHECK_EN, the ports and comparator SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-034 SHALL take the FSM state encoding, TAG_W=128 and a max3 constant function from shared package ascon_pkg.
REQ-035 SHALL place the LSB-first serial-to-parallel capture in one sub-module, ascon_sipo.
- Ports: width parameter, clk, rst, clear, enable, index, bit_in, q.
- SHALL be instantiated twice, for ciphertext and tag.

Verification
REQ-036 With defaults, pulse ready and then stream CT=0x6173636f6e and tag=0x0123456789abcdeffedcba9876543210 LSB-first.
- Required: out_valid after 131 cycles with cipher_text and tag equal to those values.
REQ-037 Hold out_ready low for 10 cycles in HOLD.
- Required: outputs stable and out_valid high throughout; one transfer when out_ready rises; IDLE next cycle.
REQ-038 Raise a second ready edge at SHIFT index 50.
- Required: overrun=1 and the first result intact.
REQ-039 Assert rst at SHIFT index 20, then run a clean transfer.
- Required: all outputs 0 during reset; the next run yields correct values with no bits from the aborted run.
REQ-040 Run with SKIP=0 and Y=160.
- Required: MAX=160, latency 161, tag taken from bits 0..127 only.
REQ-041 With ASCON_TAG_CHECK_EN, run once with matching and once with mismatching tag_expected.
- Required: tag_match 1 and 0 respectively, and 0 outside HOLD.
